// File: rtl/mem_result_collector.sv
// mem_result_collector: per-batch SMEM result buffer; collects entries, counts and
// return codes per read, then streams each read as a header line plus entry-pair lines.
module mem_result_collector #(
  parameter int MAX_READS = 256,
  parameter int MEM_DEPTH = 128,
  parameter int ENTRY_W   = 256,
  localparam int READ_W   = $clog2(MAX_READS),
  localparam int ADDR_W   = $clog2(MEM_DEPTH),
  localparam int OUT_W    = 2 * ENTRY_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic [READ_W:0]    batch_size,
  input  logic               mem_we,
  input  logic [READ_W-1:0]  mem_read_num,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [ENTRY_W-1:0] mem_data,
  input  logic               mem_size_valid,
  input  logic [READ_W-1:0]  mem_size_read_num,
  input  logic [ADDR_W:0]    mem_size,
  input  logic               ret_valid,
  input  logic [READ_W-1:0]  ret_read_num,
  input  logic [31:0]        ret,
  output logic               output_request,
  input  logic               output_permit,
  output logic [OUT_W-1:0]   output_data,
  output logic               output_valid,
  output logic               output_finish,
  output logic               size_overflow,
  output logic               protocol_err
);
  typedef enum logic [2:0] {IDLE, COLLECT, REQUEST, HEADER, BODY, FINISH} state_t;
  localparam int BANK_W = READ_W + ADDR_W - 1;
  localparam int BANK_D = MAX_READS * MEM_DEPTH / 2;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  state_t state_q, state_d;
  logic [READ_W:0] batch_q, done_cnt_q, done_cnt_d;
  logic [MAX_READS-1:0] size_seen_q, size_seen_d, ret_seen_q, ret_seen_d;
  logic [ADDR_W:0] size_mem [MAX_READS];
  logic [31:0] ret_mem [MAX_READS];
  // Even and odd entries live in separate banks so a whole line is read in one cycle.
  logic [ENTRY_W-1:0] even_mem [BANK_D];
  logic [ENTRY_W-1:0] odd_mem [BANK_D];
  logic [ENTRY_W-1:0] even_rd_q, odd_rd_q;
  logic [READ_W-1:0] rd_q, rd_d;
  logic [ADDR_W-2:0] k_q, k_d;
  logic a_v_q, a_hdr_q, a_hi_zero_q;
  logic [63:0] a_hdr_data_q;
  logic collect, frozen, issue, finish_go, last_read, last_line, size_inc, ret_inc;
  logic [ADDR_W:0] size_cur, size_in;
  logic [BANK_W-1:0] waddr, raddr;
  always_comb begin
    collect = state_q == COLLECT;
    frozen = stall && (state_q == HEADER || state_q == BODY || state_q == FINISH);
    issue = !stall && (state_q == HEADER || state_q == BODY);
    finish_go = state_q == FINISH && !stall && !a_v_q;
    output_request = state_q == REQUEST;
    size_cur = size_mem[rd_q];
    size_in = mem_size > DEPTH ? DEPTH : mem_size;
    last_read = {1'b0, rd_q} + (READ_W+1)'(1) == batch_q;
    last_line = {2'b0, k_q} == (size_cur - (ADDR_W+1)'(1)) >> 1;
    waddr = {mem_read_num, mem_addr[ADDR_W-1:1]};
    raddr = {rd_q, k_q};
  end
  // A read counts only on the edge that first makes both its flags true.
  always_comb begin
    size_seen_d = size_seen_q;
    ret_seen_d = ret_seen_q;
    if (collect && mem_size_valid) size_seen_d[mem_size_read_num] = 1'b1;
    if (collect && ret_valid) ret_seen_d[ret_read_num] = 1'b1;
    size_inc = collect && mem_size_valid && ({1'b0, mem_size_read_num} < batch_q) &&
               ret_seen_d[mem_size_read_num] &&
               !(size_seen_q[mem_size_read_num] && ret_seen_q[mem_size_read_num]);
    ret_inc = collect && ret_valid && !(mem_size_valid && mem_size_read_num == ret_read_num) &&
              ({1'b0, ret_read_num} < batch_q) && size_seen_d[ret_read_num] &&
              !(size_seen_q[ret_read_num] && ret_seen_q[ret_read_num]);
    done_cnt_d = finish_go ? '0 : done_cnt_q + (READ_W+1)'(size_inc) + (READ_W+1)'(ret_inc);
    if (finish_go) begin
      size_seen_d = '0;
      ret_seen_d = '0;
    end
  end
  always_comb begin
    state_d = state_q;
    rd_d = rd_q;
    k_d = k_q;
    case (state_q)
      IDLE: if (batch_size != '0) state_d = COLLECT;
      COLLECT: if (done_cnt_d == batch_q) state_d = REQUEST;
      REQUEST: if (output_permit) begin
        state_d = HEADER;
        rd_d = '0;
      end
      HEADER: if (!stall) begin
        if (size_cur != '0) begin
          state_d = BODY;
          k_d = '0;
        end else if (last_read) state_d = FINISH;
        else rd_d = rd_q + READ_W'(1);
      end
      BODY: if (!stall) begin
        if (!last_line) k_d = k_q + (ADDR_W-1)'(1);
        else if (last_read) state_d = FINISH;
        else begin
          state_d = HEADER;
          rd_d = rd_q + READ_W'(1);
        end
      end
      FINISH: if (finish_go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (collect && mem_size_valid) size_mem[mem_size_read_num] <= size_in;
    if (collect && ret_valid) ret_mem[ret_read_num] <= ret;
    if (collect && mem_we && !mem_addr[0]) even_mem[waddr] <= mem_data;
    if (collect && mem_we && mem_addr[0]) odd_mem[waddr] <= mem_data;
    if (issue) begin
      even_rd_q <= even_mem[raddr];
      odd_rd_q <= odd_mem[raddr];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      batch_q <= '0;
      done_cnt_q <= '0;
      size_seen_q <= '0;
      ret_seen_q <= '0;
      rd_q <= '0;
      k_q <= '0;
      a_v_q <= 1'b0;
      a_hdr_q <= 1'b0;
      a_hi_zero_q <= 1'b0;
      a_hdr_data_q <= '0;
      output_data <= '0;
      output_valid <= 1'b0;
      output_finish <= 1'b0;
      size_overflow <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      k_q <= k_d;
      done_cnt_q <= done_cnt_d;
      size_seen_q <= size_seen_d;
      ret_seen_q <= ret_seen_d;
      if (state_q == IDLE && batch_size != '0) batch_q <= batch_size;
      if (!frozen) begin
        a_v_q <= issue;
        a_hdr_q <= state_q == HEADER;
        a_hi_zero_q <= {1'b0, k_q, 1'b1} >= size_cur;
        a_hdr_data_q <= {16'(size_cur), 16'(rd_q), ret_mem[rd_q]};
      end
      output_valid <= a_v_q && !frozen;
      if (a_v_q && !frozen)
        output_data <= a_hdr_q ? OUT_W'(a_hdr_data_q) :
                       {odd_rd_q & {ENTRY_W{!a_hi_zero_q}}, even_rd_q};
      output_finish <= finish_go;
      size_overflow <= !finish_go && (size_overflow || (collect && mem_size_valid && mem_size > DEPTH));
      protocol_err <= !finish_go && (protocol_err || (!collect && (mem_we || mem_size_valid || ret_valid)));
    end
  end
endmodule

// File: doc/mem_result_collector.md
# mem_result_collector

Parametrised per-batch result buffer for the SMEM pipeline, successor to the fixed curr/mem queue RAM. Collects SMEM entries, match counts and return codes per read from the pipeline, detects when every read in the batch is complete, then arbitrates for the output module and streams each read as a header line plus packed two-entry data lines. It sits between the SMEM compute pipeline and the host output path.

## Interface
- MAX_READS, 256: reads per batch supported; READ_W = clog2(MAX_READS).
- MEM_DEPTH, 128: entries per read; ADDR_W = clog2(MEM_DEPTH).
- ENTRY_W, 256: entry width, laid out as [p_info; p_x2; p_x1; p_x0]; output width OUT_W = 2*ENTRY_W.
- Constraint: READ_W <= 16, ADDR_W+1 <= 16.

- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  freezes the output stream.
- batch_size  in  READ_W+1  reads in the current batch; sampled in IDLE.
- mem_we  in  1  entry write strobe.
- mem_read_num  in  READ_W  read index of the write.
- mem_addr  in  ADDR_W  entry slot within the read.
- mem_data  in  ENTRY_W  entry payload.
- mem_size_valid  in  1  count strobe.
- mem_size_read_num  in  READ_W  read index of the count.
- mem_size  in  ADDR_W+1  number of entries for the read.
- ret_valid  in  1  return-code strobe.
- ret_read_num  in  READ_W  read index of the return code.
- ret  in  32  return code.
- output_request  out  1  batch ready and waiting for the output module.
- output_permit  in  1  grant from the output module.
- output_data  out  OUT_W  stream line.
- output_valid  out  1  output_data qualifier.
- output_finish  out  1  one-cycle end-of-batch pulse.
- size_overflow  out  1  sticky: a mem_size value exceeded MEM_DEPTH.
- protocol_err  out  1  sticky: an input strobe arrived outside COLLECT.

## Operation
- Storage: entry RAM of MAX_READS*MEM_DEPTH x ENTRY_W, indexed {read_num, addr}, 1-cycle read latency. Per-read registers hold size, ret, size_seen and ret_seen.
- FSM states: IDLE, COLLECT, REQUEST, HEADER, BODY, FINISH.
- IDLE: if batch_size != 0, latch it and go to COLLECT. If batch_size == 0, stay in IDLE.
- COLLECT:
  - Writes, counts and return codes are accepted, including several in the same cycle.
  - A read is complete when size_seen && ret_seen. done_cnt increments once per read, on its completing edge only.
  - A repeated strobe for a read overwrites the stored value and does not recount.
  - Reads with index >= batch_size are stored but not counted.
  - When done_cnt == batch_size, go to REQUEST.
- mem_size > MEM_DEPTH: store MEM_DEPTH and set size_overflow.
- REQUEST: hold output_request=1 until output_permit is sampled high, then go to HEADER at read 0.
- HEADER: emit one line:
  - [31:0] = ret
  - [47:32] = read index (zero-extended)
  - [63:48] = size (zero-extended)
  - all other bits = 0
  - Then go to BODY if size != 0, else to the next read.
- BODY: emit ceil(size/2) lines. Line k carries entry 2k in [ENTRY_W-1:0] and entry 2k+1 in the upper half. The upper half is zero when 2k+1 >= size.
- After the last line of read batch_size-1, go to FINISH.
- FINISH:
  - Pulse output_finish for one cycle.
  - Clear all per-read flags, done_cnt and the sticky flags.
  - Go to IDLE. Entry RAM contents are not cleared.
- Strobes arriving in REQUEST, HEADER, BODY or FINISH are ignored and set protocol_err.

## Timing
- Reset value of every output is 0. FSM resets to IDLE and all flags clear.
- Reset asserted mid-stream aborts immediately; no finish pulse is produced.
- output_request rises on the cycle after the edge that completes the last read.
- First output_valid appears 2 cycles after permit is sampled (1 FSM cycle + 1 RAM latency).
- Lines are then back-to-back, one per cycle, with no gaps between reads.
- stall=1:
  - FSM, read pointers and RAM address are frozen.
  - output_valid=0 and output_data holds its value.
  - After stall falls, the pending line is presented first: no line is lost or duplicated.
- stall is ignored in IDLE, COLLECT and REQUEST.
- output_finish is asserted the cycle after the last valid line and never coincides with output_valid.
- A same-cycle write and readout of the same RAM word cannot occur, because writes are blocked outside COLLECT.

## Test plan
- batch_size=3 with sizes 1/2/3, rets 1/2/3, entries {4,3,2,1}..{24,23,22,21}, permit after request -> 7 valid lines: H0, {0,e0}, H1, {e2,e1}, H2, {e4,e3}, {0,e5}; then a finish pulse.
- Same stimulus with stall high for 2 cycles mid-BODY -> identical 7-line sequence with a 2-cycle valid gap; no line lost or duplicated.
- Read with mem_size=0, plus ret=5 sent twice -> header-only line with ret=5; done_cnt counts that read once.
- mem_size = MEM_DEPTH+1 -> stored size MEM_DEPTH, size_overflow=1, MEM_DEPTH/2 body lines.
- ret_valid strobe during BODY -> protocol_err=1; stream unchanged. Flag clears after FINISH.
- reset_n pulsed low mid-BODY -> all outputs 0 asynchronously. A new batch afterwards completes normally.
